// File: rtl/mini_sa_pkg.sv
// rtl/mini_sa_pkg.sv - shared types and constants for the mini systolic-array scheduler
package mini_sa_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int NUM_A     = 8;
  localparam int NUM_B     = 8;
  localparam int NUM_RES   = 4;
  localparam int TMR_W     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/mini_sa_scheduler_sa_run_timer.sv
// rtl/mini_sa_scheduler_sa_run_timer.sv - loadable down-counter timing the CLEAR length and RUN timeout
module sa_run_timer
  import mini_sa_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic [TMR_W-1:0] load_val,
  output logic             expire
);

  logic [TMR_W-1:0] count;

  // Load on start, zero on clear, otherwise count down to zero and stop there
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (start) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // Expire marks the last cycle of the loaded interval
  assign expire = (count == TMR_W'(1));

endmodule

// File: rtl/mini_sa_scheduler.sv
// rtl/mini_sa_scheduler.sv - job sequencer for the 2x4 by 4x2 mini systolic array (optional job prefetch: SA_SCHED_PREFETCH_EN)
module mini_sa_scheduler
  import mini_sa_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int CLR_CYCLES  = 1,
  parameter int LATENCY_MAX = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         job_valid,
  output logic                         job_ready,
  input  logic                         job_int_mul,
  input  logic [NUM_A*WIDTH-1:0]       job_a,
  input  logic [NUM_B*WIDTH-1:0]       job_b,
  output logic                         sa_reset_n,
  output logic                         sa_enable,
  output logic                         sa_int_mul,
  output logic [NUM_A*WIDTH-1:0]       sa_a,
  output logic [NUM_B*WIDTH-1:0]       sa_b,
  input  logic [NUM_RES*2*WIDTH-1:0]   sa_result,
  input  logic [2*WIDTH-1:0]           sa_importance,
  input  logic                         sa_done,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [NUM_RES*2*WIDTH-1:0]   res_data,
  output logic [2*WIDTH-1:0]           res_importance,
  output logic                         res_timeout,
  output logic                         busy
);

  localparam logic [TMR_W-1:0] CLR_VAL = TMR_W'(CLR_CYCLES);
  localparam logic [TMR_W-1:0] RUN_VAL = TMR_W'(LATENCY_MAX);

  sched_state_e state, state_nxt;

  logic                   job_fire;
  logic                   tmr_start;
  logic                   tmr_clear;
  logic [TMR_W-1:0]       tmr_val;
  logic                   tmr_expire;
  logic                   load_ops;
  logic [NUM_A*WIDTH-1:0] src_a;
  logic [NUM_B*WIDTH-1:0] src_b;
  logic                   src_int_mul;
  logic                   cap_done;
  logic                   cap_timeout;
  logic                   release_res;

`ifdef SA_SCHED_PREFETCH_EN
  logic                   buf_valid;
  logic [NUM_A*WIDTH-1:0] buf_a;
  logic [NUM_B*WIDTH-1:0] buf_b;
  logic                   buf_int_mul;
  logic                   buf_wr;
  logic                   buf_take;

  assign job_ready = ~buf_valid;
`else
  assign job_ready = (state == IDLE);
`endif

  assign job_fire = job_valid & job_ready;
  assign busy     = (state != IDLE);

  sa_run_timer u_timer (
    .clk      (clk),
    .rst      (reset),
    .start    (tmr_start),
    .clear    (tmr_clear),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  // Next-state decode; done is checked before the timeout so it wins a tie
  always_comb begin
    state_nxt   = state;
    tmr_start   = 1'b0;
    tmr_clear   = 1'b0;
    tmr_val     = CLR_VAL;
    load_ops    = 1'b0;
    src_a       = job_a;
    src_b       = job_b;
    src_int_mul = job_int_mul;
    cap_done    = 1'b0;
    cap_timeout = 1'b0;
    release_res = 1'b0;
`ifdef SA_SCHED_PREFETCH_EN
    buf_wr      = 1'b0;
    buf_take    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (job_fire) begin
          state_nxt = CLEAR;
          tmr_start = 1'b1;
          load_ops  = 1'b1;
        end
      end
      CLEAR: begin
        if (tmr_expire) begin
          state_nxt = RUN;
          tmr_start = 1'b1;
          tmr_val   = RUN_VAL;
        end
      end
      RUN: begin
        if (sa_done) begin
          state_nxt = HOLD;
          cap_done  = 1'b1;
          tmr_clear = 1'b1;
        end else if (tmr_expire) begin
          state_nxt   = HOLD;
          cap_timeout = 1'b1;
          tmr_clear   = 1'b1;
        end
      end
      HOLD: begin
        if (res_valid && res_ready) begin
          release_res = 1'b1;
          state_nxt   = IDLE;
`ifdef SA_SCHED_PREFETCH_EN
          // A waiting job starts straight away, skipping IDLE
          if (buf_valid) begin
            state_nxt   = CLEAR;
            tmr_start   = 1'b1;
            load_ops    = 1'b1;
            src_a       = buf_a;
            src_b       = buf_b;
            src_int_mul = buf_int_mul;
            buf_take    = 1'b1;
          end else if (job_fire) begin
            state_nxt = CLEAR;
            tmr_start = 1'b1;
            load_ops  = 1'b1;
          end
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
`ifdef SA_SCHED_PREFETCH_EN
    // Jobs arriving while busy are parked unless they are being launched this cycle
    if (job_fire && (state != IDLE) && !load_ops) begin
      buf_wr = 1'b1;
    end
`endif
  end

  // State, array control and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      sa_reset_n     <= 1'b0;
      sa_enable      <= 1'b0;
      sa_int_mul     <= 1'b0;
      sa_a           <= '0;
      sa_b           <= '0;
      res_valid      <= 1'b0;
      res_timeout    <= 1'b0;
      res_data       <= '0;
      res_importance <= '0;
    end else begin
      state      <= state_nxt;
      sa_reset_n <= (state_nxt != CLEAR);
      sa_enable  <= (state_nxt == RUN);
      if (load_ops) begin
        sa_a       <= src_a;
        sa_b       <= src_b;
        sa_int_mul <= src_int_mul;
      end
      if (cap_done) begin
        res_data       <= sa_result;
        res_importance <= sa_importance;
        res_valid      <= 1'b1;
        res_timeout    <= 1'b0;
      end else if (cap_timeout) begin
        res_data       <= '0;
        res_importance <= '0;
        res_valid      <= 1'b1;
        res_timeout    <= 1'b1;
      end else if (release_res) begin
        res_valid   <= 1'b0;
        res_timeout <= 1'b0;
      end
    end
  end

`ifdef SA_SCHED_PREFETCH_EN
  // One-entry job buffer filled while busy, drained when HOLD is released
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid   <= 1'b0;
      buf_a       <= '0;
      buf_b       <= '0;
      buf_int_mul <= 1'b0;
    end else if (buf_wr) begin
      buf_valid   <= 1'b1;
      buf_a       <= job_a;
      buf_b       <= job_b;
      buf_int_mul <= job_int_mul;
    end else if (buf_take) begin
      buf_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/mini_sa_scheduler.md
Name: mini_sa_scheduler

Overview:
- Sequencing controller for the 2x4 by 4x2 mini systolic array.
- Accepts one matrix job at a time over a valid/ready port and latches the A and B operands.
- Pulses the array's active-low reset, drives enable and intMul, then waits for done or a timeout.
- Captures the four results and the importance value, and presents them on a valid/ready result port.

Parameters:
- WIDTH, 8: operand width; results are 2*WIDTH.
- CLR_CYCLES, 1: number of cycles sa_reset_n is held low before each run (legal range 1..15).
- LATENCY_MAX, 16: maximum RUN cycles waiting for sa_done before a timeout (legal range 2..255).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- job_valid  in  1  job request present.
- job_ready  out  1  scheduler can accept a job.
- job_int_mul  in  1  integer-multiply mode for this job.
- job_a  in  8*WIDTH  A operands, order {a13..a10,a03..a00}; a00 in the LSBs.
- job_b  in  8*WIDTH  B operands, order {b31..b01,b30..b00}; b00 in the LSBs.
- sa_reset_n  out  1  array reset, active-low.
- sa_enable  out  1  array enable.
- sa_int_mul  out  1  array intMul.
- sa_a  out  8*WIDTH  latched A operands, stable for the whole job.
- sa_b  out  8*WIDTH  latched B operands, stable for the whole job.
- sa_result  in  4*2*WIDTH  {result3..result0} from the array.
- sa_importance  in  2*WIDTH  importance from the array.
- sa_done  in  1  array done.
- res_valid  out  1  result held.
- res_ready  in  1  consumer takes the result.
- res_data  out  4*2*WIDTH  captured results.
- res_importance  out  2*WIDTH  captured importance.
- res_timeout  out  1  the held result is a timeout (data is zero).
- busy  out  1  scheduler is not in IDLE.

Behaviour:
- Reset values:
  - state IDLE; job_ready 1; sa_reset_n 0; sa_enable 0; sa_int_mul 0.
  - sa_a, sa_b, res_data, res_importance all 0.
  - res_valid 0; res_timeout 0; busy 0; counters 0.
- All outputs are registered, except job_ready and busy, which are decoded from the state register.
- FSM states: IDLE, CLEAR, RUN, HOLD.
- IDLE:
  - job_ready=1; sa_reset_n=1; sa_enable=0.
  - On job_valid&job_ready at edge T: latch job_a, job_b and job_int_mul into sa_a, sa_b and sa_int_mul, then go to CLEAR.
- CLEAR:
  - sa_reset_n=0 and sa_enable=0 for exactly CLR_CYCLES cycles, starting at T+1.
  - Then go to RUN.
- RUN:
  - sa_reset_n=1 and sa_enable=1; the run counter counts 1..LATENCY_MAX.
  - sa_done sampled 1 at an edge: capture sa_result into res_data and sa_importance into res_importance; set res_valid=1 and res_timeout=0; clear sa_enable; go to HOLD.
  - Counter reaches LATENCY_MAX without done: set res_data=0, res_importance=0, res_valid=1, res_timeout=1; clear sa_enable; go to HOLD.
  - sa_done and the timeout in the same cycle: done wins.
  - sa_done asserted in IDLE, CLEAR or HOLD is ignored.
- HOLD:
  - sa_enable=0; res_valid=1 and the result is held stable.
  - On res_valid&res_ready: clear res_valid and res_timeout, go to IDLE.
  - res_ready asserted outside HOLD has no effect.
- Latency: job accept at edge T, then the first enable cycle is T+1+CLR_CYCLES. res_valid rises the cycle after sa_done is sampled.
- Operand stability: sa_a, sa_b and sa_int_mul change only on job accept.
- Reset mid-operation: asynchronous return to IDLE. sa_reset_n goes to 0 immediately and stays low until the first clock after reset is released. Any pending result is discarded.
- busy=1 in CLEAR, RUN and HOLD.

Optional Feature:
- Macro: SA_SCHED_PREFETCH_EN.
- When defined:
  - One-entry job buffer. job_ready=1 whenever the buffer is empty, in any state.
  - A job accepted outside IDLE is stored; on leaving HOLD it goes directly to CLEAR with the buffered operands, with no IDLE cycle.
  - A job accepted in IDLE bypasses the buffer and behaves as in the base design.
  - Reset clears the buffer.
- When undefined: job_ready=1 only in IDLE, and no buffer logic is present.

Decomposition:
- Package mini_sa_pkg holds:
  - the state enum (IDLE, CLEAR, RUN, HOLD);
  - constants NUM_A=8, NUM_B=8, NUM_RES=4;
  - the default WIDTH.
- One sub-module, sa_run_timer: loadable down-counter with start/clear inputs. It is used for both the CLEAR length and the RUN timeout, and outputs expire.

Test Plan:
- Basic job: bench array stub asserts done 4 cycles after enable and returns results 2,2,0,0, importance 5. Job a=01,00,01,00/00x4, b=01x8, intMul=1. Expect: sa_reset_n low for 1 cycle; enable high exactly 4 cycles; res_data={0,0,2,2}; res_importance=5; res_timeout=0.
- Back-pressure: res_ready held 0 for 10 cycles after res_valid. Expect res_data stable, job_ready=0, enable=0 throughout; IDLE one cycle after res_ready=1.
- Timeout: stub never asserts done, LATENCY_MAX=16. Expect exactly 16 enable cycles, then res_valid=1, res_timeout=1, res_data=0.
- Done and timeout together: stub asserts done on run cycle 16. Expect captured data and res_timeout=0.
- Reset mid-RUN: assert reset on run cycle 2. Expect sa_reset_n=0, sa_enable=0, busy=0 and res_valid=0 immediately. A new job afterwards completes normally.
- Prefetch (SA_SCHED_PREFETCH_EN): second job offered during RUN is accepted. Expect CLEAR to follow HOLD with no IDLE cycle, sa_a updated, and two results in order.
